parity_err_collector: RTL and testbench

//  Downstream collector for the dual-rail parity error flags (ERR_*/ERR_*_B pairs) produced by the
//  IP parity gen/check stage. Checks that the two rails of each channel are complementary, latches

---
 rtl/parity_err_collector_if.sv | 28 ++
 rtl/parity_err_collector.sv | 172 +++++++++++++++++
 tb/tb_parity_err_collector.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_err_collector_if.sv
// Status/handshake bundle between the parity checker, the error collector and the IRQ/safety side.
// The master drives the error rails, mask and clear request; the slave returns the collected status.
interface parity_err_collector_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int FCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ERR_IN;
  logic [NUM_CH-1:0] ERR_IN_B;
  logic [NUM_CH-1:0] ERR_MASK;
  logic              CLR_REQ;
  logic              CLR_ACK;
  logic [NUM_CH-1:0] ERR_STICKY;
  logic [NUM_CH-1:0] RAIL_FAULT;
  logic [FCH_W-1:0]  FIRST_CH;
  logic [CNT_W-1:0]  ERR_CNT;
  logic              IRQ;

  modport master (
    output ERR_IN, ERR_IN_B, ERR_MASK, CLR_REQ,
    input  CLR_ACK, ERR_STICKY, RAIL_FAULT, FIRST_CH, ERR_CNT, IRQ
  );

  modport slave (
    input  ERR_IN, ERR_IN_B, ERR_MASK, CLR_REQ,
    output CLR_ACK, ERR_STICKY, RAIL_FAULT, FIRST_CH, ERR_CNT, IRQ
  );
endinterface

// File: rtl/parity_err_collector.sv
// Dual-rail parity error collector: per-channel rail check, sticky errors, saturating event
// counter, first-channel capture and a single IRQ with a level req/ack clear handshake.

module parity_err_lane #(
  parameter int SKEW_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic err_i,
  input  logic err_b_i,
  input  logic mask_i,
  input  logic clr_i,
  output logic ev_o,
  output logic fnew_o,
  output logic sticky_o,
  output logic fault_o
);
  localparam logic [3:0] SKEW_MAX = 4'(SKEW_CYC);
  localparam logic [3:0] SKEW_M1  = 4'(SKEW_CYC - 1);

  logic       err_q, err_b_q;
  logic       vprev_q, vprev_d;
  logic       sticky_q, sticky_d;
  logic       fault_q, fault_d;
  logic [3:0] skew_q, skew_d;
  logic       v, eq, hit;

  assign v   = err_q & ~err_b_q & ~mask_i;
  assign eq  = (err_q == err_b_q);
  // the cycle that takes the run length to SKEW_CYC is the one that sets the fault
  assign hit = eq & (skew_q >= SKEW_M1);

  assign ev_o     = v & ~vprev_q;
  assign fnew_o   = hit & ~fault_q;
  assign sticky_o = sticky_q;
  assign fault_o  = fault_q;

  always_comb begin
    vprev_d  = v;
    sticky_d = sticky_q | ev_o;
    fault_d  = fault_q | hit;
    if (!eq)                   skew_d = '0;
    else if (skew_q >= SKEW_MAX) skew_d = SKEW_MAX;
    else                       skew_d = skew_q + 4'd1;
    if (clr_i) begin
      vprev_d  = 1'b0;
      sticky_d = 1'b0;
      fault_d  = 1'b0;
      skew_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q    <= 1'b0;
      err_b_q  <= 1'b0;
      vprev_q  <= 1'b0;
      sticky_q <= 1'b0;
      fault_q  <= 1'b0;
      skew_q   <= '0;
    end else begin
      err_q    <= err_i;
      err_b_q  <= err_b_i;
      vprev_q  <= vprev_d;
      sticky_q <= sticky_d;
      fault_q  <= fault_d;
      skew_q   <= skew_d;
    end
  end
endmodule

module parity_err_collector #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int SKEW_CYC = 2
) (
  input  logic                 ACLK,
  input  logic                 RESET_ACLK,
  parity_err_collector_if.slave bus
);
  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PC_W  = $clog2(NUM_CH) + 1;
  localparam int SUM_W = CNT_W + $clog2(NUM_CH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERROR = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FCH_W-1:0]  first_q, first_d, first_lo;
  logic [NUM_CH-1:0] ev, fnew, ev_g, trig, sticky, fault;
  logic [PC_W-1:0]   pop;
  logic [SUM_W-1:0]  sum;
  logic              clr;

  // clearing covers the entry edge (request seen outside CLEAR) and every edge spent in CLEAR
  assign clr = bus.CLR_REQ | (state_q == ST_CLEAR);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    parity_err_lane #(.SKEW_CYC(SKEW_CYC)) u_lane (
      .clk_i    (ACLK),
      .rst_i    (RESET_ACLK),
      .err_i    (bus.ERR_IN[i]),
      .err_b_i  (bus.ERR_IN_B[i]),
      .mask_i   (bus.ERR_MASK[i]),
      .clr_i    (clr),
      .ev_o     (ev[i]),
      .fnew_o   (fnew[i]),
      .sticky_o (sticky[i]),
      .fault_o  (fault[i])
    );
  end

  assign ev_g = clr ? '0 : ev;
  assign trig = clr ? '0 : (ev | fnew);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + PC_W'(ev_g[i]);
  end

  assign sum = SUM_W'(cnt_q) + SUM_W'(pop);

  always_comb begin
    first_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (trig[i]) first_lo = FCH_W'(i);
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (bus.CLR_REQ) state_d = ST_CLEAR;
        else if (|trig) begin
          state_d = ST_ERROR;
          first_d = first_lo;
        end
      end
      ST_ERROR: if (bus.CLR_REQ)  state_d = ST_CLEAR;
      ST_CLEAR: if (!bus.CLR_REQ) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clr) begin
      cnt_d   = '0;
      first_d = '0;
    end
  end

  always_ff @(posedge ACLK or posedge RESET_ACLK) begin
    if (RESET_ACLK) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign bus.ERR_STICKY = sticky;
  assign bus.RAIL_FAULT = fault;
  assign bus.FIRST_CH   = first_q;
  assign bus.ERR_CNT    = cnt_q;
  assign bus.IRQ        = (state_q == ST_ERROR);
  assign bus.CLR_ACK    = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_parity_err_collector.sv
// Bench for parity_err_collector: directed scenarios plus random traffic against a cycle model.
module tb_parity_err_collector;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int SKEW_CYC = 2;
  localparam int FCH_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int VW       = 2*NUM_CH + FCH_W + CNT_W + 2;

  logic ACLK = 1'b0;
  logic RESET_ACLK;

  parity_err_collector_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  parity_err_collector #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SKEW_CYC(SKEW_CYC)) dut (
    .ACLK       (ACLK),
    .RESET_ACLK (RESET_ACLK),
    .bus        (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: what the collector has seen, as plain per-channel facts
  bit [NUM_CH-1:0] m_re, m_rb, m_prev, m_sticky, m_fault;
  int m_run [NUM_CH];
  int m_cnt, m_first, m_state;   // m_state: 0 idle, 1 error, 2 clear

  task automatic model_reset();
    m_re = '0; m_rb = '0; m_prev = '0; m_sticky = '0; m_fault = '0;
    for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
    m_cnt = 0; m_first = 0; m_state = 0;
  endtask

  task automatic model_edge();
    bit clearing, v, eq, ev, nf;
    int first, nev, run;
    clearing = (m_state == 2) || bus.CLR_REQ;
    first = -1; nev = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      v  = m_re[i] && !m_rb[i] && !bus.ERR_MASK[i];
      eq = (m_re[i] == m_rb[i]);
      ev = v && !m_prev[i];
      run = eq ? m_run[i] + 1 : 0;
      if (run > SKEW_CYC) run = SKEW_CYC;
      nf = (run >= SKEW_CYC) && !m_fault[i];
      if (clearing) begin
        m_run[i] = 0; m_sticky[i] = 0; m_fault[i] = 0; m_prev[i] = 0;
      end else begin
        m_run[i] = run;
        if (ev) begin m_sticky[i] = 1; nev++; end
        if (run >= SKEW_CYC) m_fault[i] = 1;
        if ((ev || nf) && first < 0) first = i;
        m_prev[i] = v;
      end
    end
    if (clearing) begin
      m_cnt = 0; m_first = 0;
    end else begin
      m_cnt = (m_cnt + nev > CNT_MAX) ? CNT_MAX : m_cnt + nev;
    end
    case (m_state)
      0: if (bus.CLR_REQ) m_state = 2;
         else if (first >= 0) begin m_state = 1; m_first = first; end
      1: if (bus.CLR_REQ) m_state = 2;
      default: if (!bus.CLR_REQ) m_state = 0;
    endcase
    m_re = bus.ERR_IN;
    m_rb = bus.ERR_IN_B;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_sticky, m_fault, FCH_W'(m_first), CNT_W'(m_cnt), m_state == 1, m_state == 2};
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {bus.ERR_STICKY, bus.RAIL_FAULT, bus.FIRST_CH, bus.ERR_CNT, bus.IRQ, bus.CLR_ACK};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] eb);
    bus.ERR_IN = e;
    bus.ERR_IN_B = eb;
  endtask

  task automatic healthy();
    set_in('0, '1);
  endtask

  task automatic do_clear();
    bus.CLR_REQ = 1'b1;
    tick();
    bus.CLR_REQ = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET_ACLK = 1'b1;
    bus.ERR_MASK = '0;
    bus.CLR_REQ = 1'b0;
    healthy();
    @(posedge ACLK); @(posedge ACLK); #1;
    n_cmp++;
    if (got_vec() !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h required %h", got_vec(), {VW{1'b0}});
    end
    RESET_ACLK = 1'b0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || bus.IRQ !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got %h required %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_single_event();
    set_in(4'b0100, 4'b1011);
    tick();
    n_cmp++;
    if (bus.IRQ !== 1'b0 || bus.ERR_STICKY !== 4'b0000) begin
      n_bad++; $display("FAIL single_latency: irq %b sticky %b required 0 0000", bus.IRQ, bus.ERR_STICKY);
    end
    healthy();
    tick();
    n_cmp++;
    if (bus.ERR_STICKY !== 4'b0100 || bus.FIRST_CH !== 2'd2 || bus.ERR_CNT !== 8'd1 || bus.IRQ !== 1'b1) begin
      n_bad++; $display("FAIL single_event: sticky %b first %0d cnt %0d irq %b required 0100 2 1 1",
                        bus.ERR_STICKY, bus.FIRST_CH, bus.ERR_CNT, bus.IRQ);
    end
    do_clear();
  endtask

  task automatic test_clear();
    set_in(4'b0100, 4'b1011);
    tick(); tick();
    bus.CLR_REQ = 1'b1;
    tick();
    n_cmp++;
    if (bus.CLR_ACK !== 1'b1 || bus.IRQ !== 1'b0 || bus.ERR_STICKY !== '0 || bus.ERR_CNT !== '0 ||
        bus.FIRST_CH !== '0 || bus.RAIL_FAULT !== '0) begin
      n_bad++; $display("FAIL clear_entry: got %h required ack only", got_vec());
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (bus.CLR_ACK !== 1'b1 || bus.ERR_CNT !== '0) begin
        n_bad++; $display("FAIL clear_hold%0d: ack %b cnt %0d required 1 0", k, bus.CLR_ACK, bus.ERR_CNT);
      end
    end
    bus.CLR_REQ = 1'b0;
    tick();
    n_cmp++;
    if (bus.CLR_ACK !== 1'b0 || bus.IRQ !== 1'b0) begin
      n_bad++; $display("FAIL clear_exit: ack %b irq %b required 0 0", bus.CLR_ACK, bus.IRQ);
    end
    tick();
    n_cmp++;
    if (bus.ERR_STICKY !== 4'b0100 || bus.ERR_CNT !== 8'd1 || bus.IRQ !== 1'b1 || bus.FIRST_CH !== 2'd2) begin
      n_bad++; $display("FAIL clear_relatch: sticky %b cnt %0d irq %b first %0d required 0100 1 1 2",
                        bus.ERR_STICKY, bus.ERR_CNT, bus.IRQ, bus.FIRST_CH);
    end
    healthy();
    do_clear();
  endtask

  task automatic test_simultaneous_and_saturation();
    set_in(4'b1001, 4'b0110);
    tick();
    healthy();
    tick();
    n_cmp++;
    if (bus.ERR_CNT !== 8'd2 || bus.FIRST_CH !== 2'd0 || bus.ERR_STICKY !== 4'b1001) begin
      n_bad++; $display("FAIL simultaneous: cnt %0d first %0d sticky %b required 2 0 1001",
                        bus.ERR_CNT, bus.FIRST_CH, bus.ERR_STICKY);
    end
    for (int k = 0; k < 300; k++) begin
      set_in(4'b0010, 4'b1101); tick();
      healthy(); tick();
    end
    n_cmp++;
    if (bus.ERR_CNT !== 8'd255 || bus.FIRST_CH !== 2'd0) begin
      n_bad++; $display("FAIL saturate: cnt %0d first %0d required 255 0", bus.ERR_CNT, bus.FIRST_CH);
    end
    set_in(4'b1111, 4'b0000); tick();
    healthy(); tick();
    n_cmp++;
    if (bus.ERR_CNT !== 8'd255 || got_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL saturate_hold: got %h required %h", got_vec(), exp_vec());
    end
    do_clear();
  endtask

  task automatic test_rail();
    set_in(4'b0010, 4'b1111);
    tick();
    healthy();
    tick(); tick();
    n_cmp++;
    if (bus.RAIL_FAULT !== 4'b0000 || bus.IRQ !== 1'b0) begin
      n_bad++; $display("FAIL rail_short: fault %b irq %b required 0000 0", bus.RAIL_FAULT, bus.IRQ);
    end
    set_in(4'b0010, 4'b1111);
    tick(); tick();
    n_cmp++;
    if (bus.RAIL_FAULT !== 4'b0000) begin
      n_bad++; $display("FAIL rail_early: fault %b required 0000", bus.RAIL_FAULT);
    end
    healthy();
    tick();
    n_cmp++;
    if (bus.RAIL_FAULT !== 4'b0010 || bus.IRQ !== 1'b1 || bus.ERR_STICKY !== '0 || bus.FIRST_CH !== 2'd1) begin
      n_bad++; $display("FAIL rail_fault: fault %b irq %b sticky %b first %0d required 0010 1 0000 1",
                        bus.RAIL_FAULT, bus.IRQ, bus.ERR_STICKY, bus.FIRST_CH);
    end
    do_clear();
  endtask

  task automatic test_mask();
    bus.ERR_MASK = 4'b0100;
    set_in(4'b0100, 4'b1011);
    tick(); tick(); tick();
    n_cmp++;
    if (bus.ERR_STICKY !== '0 || bus.ERR_CNT !== '0 || bus.IRQ !== 1'b0) begin
      n_bad++; $display("FAIL mask_gate: sticky %b cnt %0d irq %b required 0000 0 0",
                        bus.ERR_STICKY, bus.ERR_CNT, bus.IRQ);
    end
    set_in(4'b0100, 4'b1111);
    tick(); tick(); tick();
    n_cmp++;
    if (bus.RAIL_FAULT !== 4'b0100 || bus.IRQ !== 1'b1 || bus.ERR_STICKY !== '0) begin
      n_bad++; $display("FAIL mask_rail: fault %b irq %b sticky %b required 0100 1 0000",
                        bus.RAIL_FAULT, bus.IRQ, bus.ERR_STICKY);
    end
    healthy();
    bus.ERR_MASK = '0;
    tick();
    do_clear();
  endtask

  task automatic test_reset_async();
    for (int k = 0; k < 5; k++) begin
      set_in(4'b0001, 4'b1110); tick();
      healthy(); tick();
    end
    n_cmp++;
    if (bus.ERR_CNT !== 8'd5 || bus.IRQ !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: cnt %0d irq %b required 5 1", bus.ERR_CNT, bus.IRQ);
    end
    #2 RESET_ACLK = 1'b1;
    #1;
    n_cmp++;
    if (got_vec() !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h required %h", got_vec(), {VW{1'b0}});
    end
    @(posedge ACLK); #1;
    RESET_ACLK = 1'b0;
    model_reset();
    tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || bus.IRQ !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got %h required %h", got_vec(), exp_vec());
    end
    bus.CLR_REQ = 1'b1;
    tick();
    n_cmp++;
    if (bus.CLR_ACK !== 1'b1) begin
      n_bad++; $display("FAIL ack_before_reset: ack %b required 1", bus.CLR_ACK);
    end
    #2 RESET_ACLK = 1'b1;
    #1;
    n_cmp++;
    if (bus.CLR_ACK !== 1'b0) begin
      n_bad++; $display("FAIL ack_async_drop: ack %b required 0", bus.CLR_ACK);
    end
    bus.CLR_REQ = 1'b0;
    @(posedge ACLK); #1;
    RESET_ACLK = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] e, eb;
    int bad_here;
    bad_here = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom % 16 < 2) begin
          e[i] = 1'($urandom); eb[i] = e[i];
        end else begin
          e[i] = ($urandom % 4 == 0); eb[i] = ~e[i];
        end
      end
      set_in(e, eb);
      if ($urandom % 32 == 0) bus.ERR_MASK = NUM_CH'($urandom);
      if (!bus.CLR_REQ && $urandom % 25 == 0) bus.CLR_REQ = 1'b1;
      else if (bus.CLR_REQ && m_state == 2 && $urandom % 3 == 0) bus.CLR_REQ = 1'b0;
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++;
        if (bad_here < 10) $display("FAIL random_c%0d: got %h required %h", c, got_vec(), exp_vec());
        bad_here++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_clear();
    test_simultaneous_and_saturation();
    test_rail();
    test_mask();
    test_reset_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
